// File: rtl/line_window_buffer.sv
// Multi-line buffer for a raster pixel stream. Each accepted pixel yields the column of
// NUM_TAPS previously completed lines at the same column, oldest line in tap 0.
module line_window_buffer #(
    parameter int DATA_W   = 8,
    parameter int LINE_W   = 1920,
    parameter int ADDR_W   = 11,
    parameter int NUM_TAPS = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [DATA_W-1:0]            s_data,
    input  logic                         s_sof,
    input  logic                         s_last,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [NUM_TAPS*DATA_W-1:0]   m_data,
    output logic [ADDR_W-1:0]            m_col,
    output logic                         m_win_ok,
    output logic                         err_len
);

    localparam int                NUM_LINES = NUM_TAPS + 1;
    localparam int                SEL_W     = $clog2(NUM_LINES);
    localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(LINE_W - 1);
    localparam logic [SEL_W-1:0]  TOP_LINE  = SEL_W'(NUM_TAPS);

    logic [ADDR_W-1:0]          col_q, col_d, cur_col;
    logic [SEL_W-1:0]           wr_line_q, wr_line_d, cur_line;
    logic [SEL_W-1:0]           filled_q, filled_d, cur_filled;
    logic                       m_valid_q, m_valid_d;
    logic [NUM_TAPS*DATA_W-1:0] m_data_q, m_data_d;
    logic [ADDR_W-1:0]          m_col_q, m_col_d;
    logic                       m_win_ok_q, m_win_ok_d;
    logic                       err_len_q, err_len_d;
    logic                       accept, eol;
    logic [NUM_LINES-1:0]       ram_we;
    logic [DATA_W-1:0]          rd_data [NUM_LINES];

    function automatic logic [SEL_W-1:0] tap_line(input logic [SEL_W-1:0] base, input int t);
        int sel;
        sel = (int'(base) + 1 + t) % NUM_LINES;
        return SEL_W'(sel);
    endfunction

    for (genvar l = 0; l < NUM_LINES; l++) begin : g_line
        logic [DATA_W-1:0] mem [LINE_W];

        // NOTE: line storage has no reset; only the control state above it is cleared.
        always_ff @(posedge clk) begin
            if (ram_we[l]) mem[cur_col] <= s_data;
        end

        assign rd_data[l] = mem[cur_col];
    end

    assign s_ready = !rst && (!m_valid_q || m_ready);
    assign accept  = s_valid && s_ready;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        cur_col    = s_sof ? '0 : col_q;
        cur_line   = s_sof ? '0 : wr_line_q;
        cur_filled = s_sof ? '0 : filled_q;
        eol        = s_last || (cur_col == LAST_COL);
        ram_we     = '0;
        col_d      = col_q;
        wr_line_d  = wr_line_q;
        filled_d   = filled_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_col_d    = m_col_q;
        m_win_ok_d = m_win_ok_q;
        err_len_d  = err_len_q;

        if (accept) begin
            ram_we[cur_line] = 1'b1;
            m_valid_d        = 1'b1;
            m_col_d          = cur_col;
            m_win_ok_d       = (cur_filled == TOP_LINE);
            for (int t = 0; t < NUM_TAPS; t++) begin
                m_data_d[t*DATA_W +: DATA_W] = rd_data[tap_line(cur_line, t)];
            end
            // Short line, long line and a frame start mid-line are all length errors.
            if ((s_sof && col_q != '0) || (s_last != (cur_col == LAST_COL))) begin
                err_len_d = 1'b1;
            end
            if (eol) begin
                col_d     = '0;
                wr_line_d = (cur_line == TOP_LINE) ? '0 : cur_line + 1'b1;
                filled_d  = (cur_filled == TOP_LINE) ? cur_filled : cur_filled + 1'b1;
            end else begin
                col_d     = cur_col + 1'b1;
                wr_line_d = cur_line;
                filled_d  = cur_filled;
            end
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q      <= '0;
            wr_line_q  <= '0;
            filled_q   <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_col_q    <= '0;
            m_win_ok_q <= 1'b0;
            err_len_q  <= 1'b0;
        end else begin
            col_q      <= col_d;
            wr_line_q  <= wr_line_d;
            filled_q   <= filled_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_col_q    <= m_col_d;
            m_win_ok_q <= m_win_ok_d;
            err_len_q  <= err_len_d;
        end
    end

    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign m_col    = m_col_q;
    assign m_win_ok = m_win_ok_q;
    assign err_len  = err_len_q;

endmodule

// File: tb/tb_line_window_buffer.sv
// Self-checking bench for line_window_buffer: directed and randomized streams compared
// against a model that keeps the last completed lines of the current frame.
module tb_line_window_buffer;

    localparam int DW = 8;
    localparam int LW = 4;
    localparam int AW = 2;
    localparam int NT = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [DW-1:0]  s_data = '0;
    logic           s_sof = 1'b0;
    logic           s_last = 1'b0;
    logic           m_valid;
    logic           m_ready = 1'b1;
    logic [NT*DW-1:0] m_data;
    logic [AW-1:0]  m_col;
    logic           m_win_ok;
    logic           err_len;

    always #5 clk = ~clk;

    line_window_buffer #(.DATA_W(DW), .LINE_W(LW), .ADDR_W(AW), .NUM_TAPS(NT)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_col(m_col),
        .m_win_ok(m_win_ok), .err_len(err_len)
    );

    typedef struct packed {
        logic [LW*DW-1:0] pix;
        logic [LW-1:0]    vld;
    } line_t;

    line_t          hist[$];
    line_t          cur_l;
    int             cur_col;
    logic           exp_mv, exp_ok, exp_err, exp_known;
    logic [AW-1:0]  exp_col;
    logic [NT*DW-1:0] exp_data;

    int checks = 0;
    int errors = 0;
    int beats = 0;
    int stall_left = 0;
    bit rand_rdy = 0;
    bit rand_gap = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        cur_l     = '0;
        cur_col   = 0;
        exp_mv    = 1'b0;
        exp_ok    = 1'b0;
        exp_err   = 1'b0;
        exp_col   = '0;
        exp_data  = '0;
        exp_known = 1'b1;
    endtask

    // Taps are the last NT completed lines of the frame; columns a short line never wrote are unknown.
    task automatic model_accept(input logic [DW-1:0] d, input logic sof, input logic last);
        int c;
        c = cur_col;
        if (sof) begin
            if (c != 0) exp_err = 1'b1;
            c = 0;
            hist.delete();
            cur_l = '0;
        end
        exp_mv    = 1'b1;
        exp_col   = AW'(c);
        exp_ok    = (hist.size() == NT);
        exp_known = exp_ok;
        if (exp_ok) begin
            for (int t = 0; t < NT; t++) begin
                if (!hist[t].vld[c]) exp_known = 1'b0;
                exp_data[t*DW +: DW] = hist[t].pix[c*DW +: DW];
            end
        end
        cur_l.pix[c*DW +: DW] = d;
        cur_l.vld[c] = 1'b1;
        if (last != (c == LW - 1)) exp_err = 1'b1;
        if (last || c == LW - 1) begin
            hist.push_back(cur_l);
            if (hist.size() > NT) void'(hist.pop_front());
            cur_l   = '0;
            cur_col = 0;
        end else begin
            cur_col = c + 1;
        end
    endtask

    task automatic check_outputs();
        check("m_valid", m_valid, exp_mv);
        check("m_col", m_col, exp_col);
        check("m_win_ok", m_win_ok, exp_ok);
        check("err_len", err_len, exp_err);
        if (exp_known) check("m_data", m_data, exp_data);
    endtask

    task automatic get_rdy(output logic r);
        if (stall_left > 0) begin
            stall_left--;
            r = 1'b0;
        end else if (rand_rdy) begin
            r = ($urandom_range(0, 3) != 0);
        end else begin
            r = 1'b1;
        end
    endtask

    task automatic step(input logic v, input logic [DW-1:0] d, input logic sof, input logic last,
                        input logic rdy, output logic acc);
        logic exp_rdy;
        s_valid = v;
        s_data  = d;
        s_sof   = sof;
        s_last  = last;
        m_ready = rdy;
        #1;
        exp_rdy = !exp_mv || rdy;
        check("s_ready", s_ready, exp_rdy);
        if (m_valid && rdy) beats++;
        acc = v && exp_rdy;
        @(posedge clk);
        #1;
        if (acc) model_accept(d, sof, last);
        else if (rdy) exp_mv = 1'b0;
        check_outputs();
    endtask

    task automatic send(input logic [DW-1:0] d, input logic sof, input logic last);
        logic acc, r;
        int tries;
        acc = 1'b0;
        tries = 0;
        while (!acc) begin
            if (rand_gap && $urandom_range(0, 3) == 0) begin
                get_rdy(r);
                step(1'b0, '0, 1'b0, 1'b0, r, acc);
            end
            get_rdy(r);
            step(1'b1, d, sof, last, r, acc);
            tries++;
            if (!acc && tries > 40) begin
                checks++;
                errors++;
                $error("FAIL send_timeout: observed %0d attempts expected acceptance", tries);
                break;
            end
        end
    endtask

    task automatic send_line(input int l, input bit sof_first, input bit randdata,
                             input int len, input bit set_last);
        logic [DW-1:0] d;
        for (int c = 0; c < len; c++) begin
            d = randdata ? DW'($urandom) : DW'(16 * l + c);
            send(d, sof_first && c == 0, set_last && c == len - 1);
        end
    endtask

    task automatic drain();
        logic acc;
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        #1;
        check("s_ready_in_rst", s_ready, 1'b0);
        @(posedge clk);
        #1;
        model_reset();
        check_outputs();
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Six patterned lines with a 5-cycle downstream stall mid line 2.
        beats = 0;
        for (int l = 0; l < 6; l++) begin
            for (int c = 0; c < LW; c++) begin
                if (l == 2 && c == 1) stall_left = 5;
                send(DW'(16 * l + c), l == 0 && c == 0, c == LW - 1);
                if (l == 3 && c == 1) begin
                    check("line3_taps", m_data, {8'h21, 8'h11, 8'h01});
                    check("line3_win_ok", m_win_ok, 1'b1);
                end
                if (l == 2 && c == 3) check("line2_win_ok", m_win_ok, 1'b0);
                if (l == 5 && c == 2) check("line5_taps", m_data, {8'h42, 8'h32, 8'h22});
            end
        end
        drain();
        check("beat_count", beats, 24);

        // Short line, then a line missing its s_last.
        do_reset();
        send_line(0, 1, 1, LW, 1);
        send_line(1, 0, 1, 3, 1);
        check("err_short", err_len, 1'b1);
        send(DW'($urandom), 1'b0, 1'b0);
        check("col_after_short", m_col, 2'd0);
        send_line(2, 0, 1, 3, 1);
        do_reset();
        check("err_cleared", err_len, 1'b0);
        send_line(0, 1, 1, LW, 0);
        check("err_long", err_len, 1'b1);
        send(DW'($urandom), 1'b0, 1'b0);
        check("col_after_long", m_col, 2'd0);
        send_line(1, 0, 1, 3, 1);

        // Frame start arriving mid-line.
        do_reset();
        send_line(0, 1, 1, LW, 1);
        send_line(1, 0, 1, LW, 1);
        send_line(2, 0, 1, 2, 0);
        send(DW'($urandom), 1'b1, 1'b0);
        check("sof_mid_win_ok", m_win_ok, 1'b0);
        check("sof_mid_err", err_len, 1'b1);
        check("sof_mid_col", m_col, 2'd0);
        send_line(3, 0, 1, 3, 1);
        send_line(4, 0, 1, LW, 1);
        send_line(5, 0, 1, LW, 1);
        send(DW'($urandom), 1'b0, 1'b0);
        check("new_frame_win_ok", m_win_ok, 1'b1);
        send_line(6, 0, 1, 3, 1);

        // Reset pulse mid-line, then restream.
        send_line(7, 0, 1, 2, 0);
        do_reset();
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, '0);
        for (int l = 0; l < 4; l++) send_line(l, l == 0, 1, LW, 1);
        drain();

        // Randomized traffic: random lengths, back-pressure, gaps, occasional frame starts.
        rand_rdy = 1;
        rand_gap = 1;
        send_line(0, 1, 1, LW, 1);
        for (int l = 1; l < 30; l++) begin
            int len;
            bit lst;
            len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, LW)) : LW;
            lst = (len < LW) ? 1'b1 : ($urandom_range(0, 5) != 0);
            send_line(l, $urandom_range(0, 9) == 0, 1, len, lst);
        end
        rand_rdy = 0;
        rand_gap = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_window_buffer.md
Name: line_window_buffer

Overview:
- Parametrised multi-line buffer with internal addressing.
- Holds NUM_TAPS completed lines plus one line currently being written, giving NUM_TAPS+1 line RAMs in rotation.
- Accepts a raster pixel stream. For each accepted pixel it outputs the vertical column of NUM_TAPS stored pixels at the same column, oldest line first.
- Sits between the pixel source and the 2-D window/filter stage. It replaces externally driven RAM address and write-enable control with its own column counter, line rotation, handshake and line-length checking.

Parameters:
- DATA_W, 8, pixel width in bits.
- LINE_W, 1920, pixels per line.
- ADDR_W, 11, column address width; must satisfy 2^ADDR_W >= LINE_W.
- NUM_TAPS, 7, completed lines presented per column; number of line RAMs = NUM_TAPS+1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  input pixel accepted when s_valid && s_ready.
- s_data  in  DATA_W  input pixel.
- s_sof  in  1  first pixel of frame; qualified by s_valid && s_ready.
- s_last  in  1  last pixel of line; qualified by s_valid && s_ready.
- m_valid  out  1  output column valid.
- m_ready  in  1  downstream accept.
- m_data  out  NUM_TAPS*DATA_W  column taps; bits [DATA_W-1:0] = tap0 = oldest line.
- m_col  out  ADDR_W  column index of m_data.
- m_win_ok  out  1  all NUM_TAPS taps hold lines of the current frame.
- err_len  out  1  sticky line-length error.

Behaviour:
- Reset values: s_ready=0 during rst, then follows its equation; m_valid=0, m_data=0, m_col=0, m_win_ok=0, err_len=0. Internal: col=0, wr_line=0, lines_filled=0.
- Reset mid-frame discards all state; RAM contents are not cleared. m_win_ok=0 until NUM_TAPS new lines are filled.
- Handshake: accept = s_valid && s_ready; s_ready = !m_valid || m_ready (single output register, no bubble).
- m_valid rises in the cycle after accept, i.e. latency 1 cycle.
- m_valid and the m_* fields hold stable while m_valid && !m_ready.
- m_valid clears when m_ready is high and no new accept occurs.
- On accept:
  - Write s_data to RAM[wr_line] at address col.
  - In the same cycle, read all other RAMs asynchronously at col, before the write takes effect.
  - Register tap t = RAM[(wr_line+1+t) mod (NUM_TAPS+1)], so tap NUM_TAPS-1 = most recent completed line.
  - m_col <= col.
  - m_win_ok <= (lines_filled == NUM_TAPS).
- Column counter:
  - Increments on accept.
  - End of line occurs on accept with s_last=1, or on accept with col==LINE_W-1.
  - At end of line: col <= 0; wr_line <= (wr_line==NUM_TAPS) ? 0 : wr_line+1; lines_filled <= min(lines_filled+1, NUM_TAPS), saturating.
- Length check (err_len sticky until rst):
  - s_last with col != LINE_W-1 (short line) sets err_len.
  - col==LINE_W-1 without s_last (long line) sets err_len and forces end of line.
- Frame start: accept with s_sof=1 treats the pixel as column 0 of a new frame.
  - Write at address 0 to RAM[0]; taps read with wr_line=0.
  - m_col <= 0; m_win_ok <= 0.
  - Next col=1, wr_line=0, lines_filled=0.
  - s_sof with s_last in the same beat: sof applied first, then end of line; lines_filled becomes 1.
  - s_sof arriving mid-line sets err_len.
- Simultaneous accept and m_ready: output register reloads with the new column; no beat is lost or duplicated.
- RAMs: distributed, one per line, combinational read, synchronous write, depth LINE_W, one write-enable each.

Test Plan:
- NUM_TAPS=3, LINE_W=4. Stream 4 lines, pixel value = 16*line+col, sof on the first pixel, last on col 3, m_ready=1.
  - Line 3 outputs taps {0x00..0x03, 0x10.., 0x20..}, oldest in tap0.
  - m_win_ok=1 only during line 3.
  - Latency exactly 1 cycle.
- Same stream continued over 6 lines: wr_line wraps 3->0.
  - Line 5 taps = lines 2,3,4 in order.
  - lines_filled stays saturated at 3.
- Hold m_ready=0 for 5 cycles mid-line with s_valid=1.
  - s_ready=0 after the first beat; m_data and m_col held.
  - No pixel is lost or duplicated after release; count output beats = 24.
- s_last at col 2, and separately a missing s_last at col 3.
  - err_len=1 in both cases; line rotates; next pixel has m_col=0.
- s_sof asserted mid-line 2.
  - m_win_ok=0, err_len=1.
  - After 3 more full lines, m_win_ok=1 with taps from the new frame only.
- rst pulsed for 1 cycle mid-line.
  - All outputs return to 0 the next cycle.
  - Restream shows m_win_ok=0 until 3 lines are filled.
